tt_um_addk_stream: RTL and testbench



---
 rtl/tt_um_addk_stream.sv | 173 +++++++++++++++++
 tb/tb_tt_um_addk_stream.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_addk_stream.sv
// tt_um_addk_stream: streaming add-constant / accumulate / saturate / subtract unit.
// Operands enter on a valid/ready handshake. They pass through PIPE_STAGES result
// registers and are stored in a FIFO that is drained by a pop handshake.
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   ena         design selected; low freezes all state
//   ui_in       operand
//   uio_in      [0] in_valid, [1] out_ready, [3:2] mode, [4] clr, [7:5] ignored
//   uo_out      FIFO head result, 0 when empty
//   uio_out     [4] out_valid, [5] in_ready, [6] ovf_sticky, [7] head carry
//   uio_oe      constant 8'hF0

package tt_um_addk_stream_pkg;
    // One FIFO / pipeline entry: carry or borrow flag plus 8-bit result.
    typedef struct packed {
        logic       c;
        logic [7:0] r;
    } entry_t;
endpackage

module tt_um_addk_stream
    import tt_um_addk_stream_pkg::*;
#(
    parameter int unsigned ADD_CONST   = 42,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RW = $clog2(FIFO_DEPTH + PIPE_STAGES + 1);
    localparam logic [8:0]  K9 = 9'(ADD_CONST);

    logic       in_valid;
    logic       out_ready;
    logic [1:0] mode;
    logic       clr;
    logic       unused_uio;

    assign in_valid   = uio_in[0];
    assign out_ready  = uio_in[1];
    assign mode       = uio_in[3:2];
    assign clr        = uio_in[4];
    assign unused_uio = &{1'b0, uio_in[7:5]};

    logic [7:0]             acc;
    logic                   ovf_sticky;
    logic [PIPE_STAGES-1:0] pipe_vld;
    entry_t                 pipe_data [PIPE_STAGES];
    entry_t                 mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          fifo_count;

    logic [RW-1:0] inflight_c;
    logic          in_ready_c;
    logic          out_valid_c;
    logic          accept_c;
    logic          push_c;
    logic          pop_c;
    logic          acc_accept_c;
    logic [8:0]    sum_add_c;
    logic [8:0]    sum_acc_c;
    logic [8:0]    diff_c;
    entry_t        res_c;
    entry_t        head_c;

    // Reservation count: stored results plus results still in the pipeline.
    always_comb begin
        inflight_c = '0;
        for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            inflight_c = inflight_c + RW'(pipe_vld[i]);
        end
    end

    assign in_ready_c   = (RW'(fifo_count) + inflight_c) < RW'(FIFO_DEPTH);
    assign out_valid_c  = fifo_count != '0;
    assign accept_c     = in_valid & in_ready_c & ena;
    assign push_c       = pipe_vld[PIPE_STAGES-1] & ena;
    assign pop_c        = out_ready & out_valid_c & ena;
    assign acc_accept_c = accept_c & (mode == 2'b01);

    // Result for the operand being accepted this cycle.
    always_comb begin
        sum_add_c = {1'b0, ui_in} + K9;
        sum_acc_c = {1'b0, acc} + {1'b0, ui_in};
        diff_c    = {1'b0, ui_in} - K9;
        res_c     = '0;
        case (mode)
            2'b00: begin
                res_c.r = sum_add_c[7:0];
                res_c.c = sum_add_c[8];
            end
            2'b01: begin
                // A clear on the same edge restarts the chain from this operand.
                res_c.r = clr ? ui_in : sum_acc_c[7:0];
                res_c.c = clr ? 1'b0  : sum_acc_c[8];
            end
            2'b10: begin
                res_c.r = sum_add_c[8] ? 8'hFF : sum_add_c[7:0];
                res_c.c = sum_add_c[8];
            end
            default: begin
                res_c.r = diff_c[7:0];
                res_c.c = diff_c[8];
            end
        endcase
    end

    // Control state: pipeline valids, accumulator, sticky flag, FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld   <= '0;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (ena) begin
            pipe_vld[0] <= accept_c;
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end

            if (clr) begin
                acc <= acc_accept_c ? ui_in : 8'h00;
            end else if (acc_accept_c) begin
                acc <= sum_acc_c[7:0];
            end

            if (clr) begin
                ovf_sticky <= 1'b0;
            end else if (push_c && pipe_data[PIPE_STAGES-1].c) begin
                ovf_sticky <= 1'b1;
            end

            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            if (push_c && !pop_c) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push_c && pop_c) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    // Datapath registers; contents are qualified by the valid bits and count.
    always_ff @(posedge clk) begin
        if (ena) begin
            pipe_data[0] <= res_c;
            for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                pipe_data[i] <= pipe_data[i-1];
            end
            if (push_c) begin
                mem[wr_ptr] <= pipe_data[PIPE_STAGES-1];
            end
        end
    end

    assign head_c  = mem[rd_ptr];
    assign uo_out  = out_valid_c ? head_c.r : 8'h00;
    assign uio_out = {out_valid_c & head_c.c, ovf_sticky, in_ready_c, out_valid_c, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_addk_stream.sv
// Directed bench for tt_um_addk_stream with default parameters (42, 2 stages, depth 4).
module tb_tt_um_addk_stream;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic       in_valid;
    logic       out_ready;
    logic       clr;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;

    assign uio_in = {3'b101, clr, mode, out_ready, in_valid};

    always #5 clk = ~clk;

    tt_um_addk_stream dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] m, input logic [7:0] v);
        mode     = m;
        ui_in    = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp_r, input logic exp_c);
        check({tag, "_valid"}, 16'(uio_out[4]), 16'd1);
        check({tag, "_r"}, 16'(uo_out), 16'(exp_r));
        check({tag, "_c"}, 16'(uio_out[7]), 16'(exp_c));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [1:0] m, input logic [7:0] v,
                           input logic [7:0] exp_r, input logic exp_c);
        push(m, v);
        step();
        step();
        pop_check(tag, exp_r, exp_c);
        check({tag, "_empty"}, 16'(uio_out[4]), 16'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        ui_in     = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        mode      = 2'b00;
        #12;
        check("rst_uo", 16'(uo_out), 16'h00);
        check("rst_uio", 16'(uio_out), 16'h20);
        check("rst_oe", 16'(uio_oe), 16'hF0);
        rst_n = 1'b1;
        step();

        // Mode 00 latency: not visible one edge after accept, visible after two.
        push(2'b00, 8'd200);
        check("m00_lat1", 16'(uio_out[4]), 16'd0);
        step();
        check("m00_lat1b", 16'(uio_out[4]), 16'd0);
        step();
        pop_check("m00_200", 8'd242, 1'b0);
        check("m00_ovf0", 16'(uio_out[6]), 16'd0);

        push(2'b00, 8'd250);
        step();
        step();
        check("m00_ovf1", 16'(uio_out[6]), 16'd1);
        pop_check("m00_250", 8'd36, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_ovf", 16'(uio_out[6]), 16'd0);

        run_one("m10_250", 2'b10, 8'd250, 8'd255, 1'b1);
        run_one("m10_13",  2'b10, 8'd13,  8'd55,  1'b0);
        run_one("m11_10",  2'b11, 8'd10,  8'd224, 1'b1);
        run_one("m11_50",  2'b11, 8'd50,  8'd8,   1'b0);

        // Back-to-back accumulate.
        mode     = 2'b01;
        ui_in    = 8'd100;
        in_valid = 1'b1;
        step();
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        pop_check("acc1", 8'd100, 1'b0);
        pop_check("acc2", 8'd200, 1'b0);
        pop_check("acc3", 8'd44,  1'b1);
        check("acc_empty", 16'(uio_out[4]), 16'd0);

        // Clear coinciding with an accumulate accept restarts from the operand.
        clr = 1'b1;
        push(2'b01, 8'd7);
        clr = 1'b0;
        check("clr_acc_ovf", 16'(uio_out[6]), 16'd0);
        step();
        step();
        pop_check("acc_clr7", 8'd7, 1'b0);
        run_one("acc_after", 2'b01, 8'd1, 8'd8, 1'b0);

        // Backpressure: six offers with the FIFO not draining.
        mode = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            ui_in    = 8'(i);
            in_valid = 1'b1;
            check($sformatf("bp_rdy%0d", i), 16'(uio_out[5]), (i <= 4) ? 16'd1 : 16'd0);
            step();
        end
        in_valid = 1'b0;
        check("bp_full_rdy", 16'(uio_out[5]), 16'd0);
        pop_check("bp_43", 8'd43, 1'b0);
        check("bp_rdy_after_pop", 16'(uio_out[5]), 16'd1);

        // Reserve the freed slot, then pop on the edge that result lands.
        push(2'b00, 8'd100);
        check("bp_resv_full", 16'(uio_out[5]), 16'd0);
        step();
        check("bp_head44", 16'(uo_out), 16'd44);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_simul_rdy", 16'(uio_out[5]), 16'd1);
        pop_check("bp_45", 8'd45, 1'b0);
        pop_check("bp_46", 8'd46, 1'b0);
        pop_check("bp_142", 8'd142, 1'b0);
        check("bp_empty", 16'(uio_out[4]), 16'd0);

        // Freeze mid-pipeline; offers and pops while frozen have no effect.
        push(2'b00, 8'd5);
        step();
        ena      = 1'b0;
        in_valid = 1'b1;
        ui_in    = 8'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("frz_valid%0d", i), 16'(uio_out[4]), 16'd0);
        end
        in_valid = 1'b0;
        ena      = 1'b1;
        step();
        check("frz_resume", 16'(uo_out), 16'd47);
        ena       = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        ena       = 1'b1;
        pop_check("frz_hold", 8'd47, 1'b0);
        step();
        step();
        check("frz_no_extra", 16'(uio_out[4]), 16'd0);

        // Reset mid-stream with one stored result and one in flight.
        mode     = 2'b00;
        ui_in    = 8'd250;
        in_valid = 1'b1;
        step();
        ui_in    = 8'd21;
        step();
        in_valid = 1'b0;
        step();
        check("mid_ovf", 16'(uio_out[6]), 16'd1);
        check("mid_valid", 16'(uio_out[4]), 16'd1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_uo", 16'(uo_out), 16'h00);
        check("mid_rst_uio", 16'(uio_out), 16'h20);
        check("mid_rst_oe", 16'(uio_oe), 16'hF0);
        #3;
        rst_n = 1'b1;
        step();
        step();
        step();
        check("post_rst_uio", 16'(uio_out), 16'h20);
        check("post_rst_uo", 16'(uo_out), 16'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
